keypad_scanner: RTL and testbench
=================================

# keypad_scanner

- Scans a 4x4 active-low matrix keypad and emits a debounced 4-bit key code with a one-cycle valid pulse.
- Input-side counterpart of the multiplexed four-digit display driver: it drives one column line at a time and reads the row lines back.
- `key_code` is in hex range 0-F, so it can feed a digit input of the display driver directly.
- Sits between the board keypad pins and the lab top-level.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column stays driven (dwell). Must be at least 4.
- `DEBOUNCE_CNT`, default 4: number of consecutive identical scan frames required to accept a press or a release. Must be at least 1.
- `clk` input 1: single system clock. All logic is on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `row` input 4: keypad rows, active-low, pulled up externally, asynchronous to `clk`.
- `col` output 4: column drive, active-low, exactly one bit low at any time.
- `key_code` output 4: code of the accepted key, `row_idx*4 + col_idx`. Holds its value until the next accepted press.
- `key_valid` output 1: one-cycle pulse when a press is accepted.
- `key_held` output 1: high from acceptance of a press until acceptance of its release.

## Operation
- **Row synchronization:** `row` passes through a 2-flop synchronizer. Both flops reset to 4'b1111.
- **Column scan:**
  - Dwell counter runs 0..SCAN_DIV-1.
  - `col_idx` advances 0→1→2→3→0 when the dwell counter wraps.
  - `col` = ~(1 << `col_idx`).
- **Sampling:** synchronized rows are sampled on the dwell cycle SCAN_DIV-1 of each column. A sampled row bit at 0 means key (that row, `col_idx`) is pressed.
- **Frames:** one frame = 4 columns = 4*SCAN_DIV cycles. It is evaluated on the column-3 sample cycle.
- **Frame result:** either "none", or the lowest pressed key code in that frame.
- **Debounce FSM:** `cnt` counts frames and saturates at DEBOUNCE_CNT.
  - **IDLE**
    - Frame result "none": stay.
    - Frame result key k: `cand`=k, `cnt`=1, go to DEBOUNCE.
  - **DEBOUNCE**
    - Same k: `cnt`+1.
    - Different key: `cand`=new key, `cnt`=1.
    - "none": go to IDLE.
  - **Acceptance:** when `cnt` reaches DEBOUNCE_CNT:
    - `key_code`=`cand`, pulse `key_valid`, `key_held`=1, go to PRESSED.
    - If DEBOUNCE_CNT=1, this happens directly from IDLE.
  - **PRESSED**
    - Frame contains `cand`: stay.
    - Otherwise: `cnt`=1, go to RELEASE.
  - **RELEASE**
    - Frame lacks `cand`: `cnt`+1. At DEBOUNCE_CNT, `key_held`=0 and go to IDLE.
    - Frame contains `cand`: go back to PRESSED with no new pulse.
- **Arithmetic:**
  - Dwell counter width is $clog2(SCAN_DIV).
  - `cnt` width is $clog2(DEBOUNCE_CNT+1).
- **Reset mid-operation:** all state is cleared asynchronously.
  - No pulse is generated on reset exit.
  - A key held through reset must be fully re-debounced.

## Timing
- **Reset values:** `col`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0, FSM=IDLE, all counters 0.
- **Scan start:** the first column advance occurs SCAN_DIV cycles after `rst` deasserts.
- **Output update:** `key_valid` and `key_held` rise in the cycle after the accepting column-3 sample cycle. `key_code` updates in that same cycle.
- **Pulse width:** `key_valid` is high for exactly one cycle per accepted press.
- **Press latency:** (DEBOUNCE_CNT frames + 1 cycle) after the first full frame in which the key is seen.
- **Release latency:** `key_held` falls one cycle after the DEBOUNCE_CNT-th consecutive frame without the key.
- **Sampling margin:** the sample point sits SCAN_DIV-1 cycles into the dwell. This covers the 2-cycle synchronizer delay plus settling.

## Configuration
- **Macro:** `KEYPAD_MULTI_REJECT_EN`.
- **Defined:** a frame with more than one pressed key counts as "none" (ghosting rejection).
- **Not defined:** the lowest key code in the frame wins.

## Structure
- **Package `keypad_pkg`:**
  - FSM state enum: IDLE, DEBOUNCE, PRESSED, RELEASE.
  - `NUM_COLS`=4, `NUM_ROWS`=4.
  - `KEY_W`=4.
- **Sub-module `row_sync`:** parameterized-width 2-flop synchronizer with an asynchronous active-low reset value input. Instantiated once.
- **Everything else:** scan counter, frame evaluation and FSM live in `keypad_scanner`.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=2 (frame = 16 cycles).
1. **Reset:** hold `rst`=0 for 3 cycles → `col`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0. Release `rst` → `col`=4'b1101 after 4 cycles.
2. **Press:** pull row 1 low only while `col`=4'b1011 (key 6), for 5 frames → exactly one `key_valid` pulse, with `key_code`=6, one cycle after the 2nd complete frame. `key_held`=1 thereafter.
3. **Bounce:** key 6 present for 1 frame, then absent for 1 frame, repeated 4 times → no `key_valid`, `key_held` stays 0.
4. **Release:** continuing from scenario 2, release key 6 → `key_held` falls one cycle after the 2nd empty frame. A 1-frame release glitch leaves `key_held`=1 with no new pulse.
5. **Two keys:** keys 1 and 6 pressed together →
   - without `KEYPAD_MULTI_REJECT_EN`: `key_code`=1, one pulse;
   - with it defined: no pulse.
6. **Reset mid-PRESSED:** pulse `rst` low while key 6 is held → `key_held`=0 immediately. The next pulse, `key_code`=6, arrives only after 2 new full frames.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, dimensions and frame-decode helpers for the 4x4 keypad scanner.
// Pure declarations: no latency, no flow control.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int KEY_W    = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    function automatic logic [KEY_W-1:0] lowest_key(input logic [NUM_KEYS-1:0] mask);
        logic [KEY_W-1:0] k;
        k = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (mask[i]) k = KEY_W'(i);
        end
        return k;
    endfunction

    function automatic logic multi_key(input logic [NUM_KEYS-1:0] mask);
        return |(mask & (mask - NUM_KEYS'(1)));
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines; reset loads rst_val.
// Latency 2 cycles; no backpressure.
module row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= rst_val;
            sync_q <= rst_val;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with frame debounce; key_valid one cycle after the accepting frame.
// No backpressure. KEYPAD_MULTI_REJECT_EN: frames with more than one key pressed count as empty.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [NUM_ROWS-1:0] row_s;

    row_sync #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clk     (clk),
        .rst     (rst),
        .rst_val ({NUM_ROWS{1'b1}}),
        .d       (row),
        .q       (row_s)
    );

    logic [DIV_W-1:0]    dwell_q;
    logic [1:0]          col_idx_q;
    logic [NUM_KEYS-1:0] frame_q, frame_d;
    state_t              state_q, state_d;
    logic [KEY_W-1:0]    cand_q, cand_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [KEY_W-1:0]    key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_held_q, key_held_d;

    logic                sample;
    logic                frame_eval;
    logic                hit;
    logic [KEY_W-1:0]    hit_key;
    logic                has_cand;
    logic [CNT_W-1:0]    cnt_inc;

    assign sample     = (dwell_q == DWELL_LAST);
    assign frame_eval = sample && (col_idx_q == 2'd3);

    // frame_d holds this frame's pressed-key map including the column sampled right now.
    always_comb begin
        frame_d = frame_q;
        if (sample) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                frame_d[{r[1:0], col_idx_q}] = ~row_s[r[1:0]];
            end
        end
    end

    assign hit_key  = lowest_key(frame_d);
    assign has_cand = frame_d[cand_q];
`ifdef KEYPAD_MULTI_REJECT_EN
    assign hit      = (|frame_d) && !multi_key(frame_d);
`else
    assign hit      = |frame_d;
`endif
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_q   <= '0;
            col_idx_q <= '0;
            frame_q   <= '0;
        end else begin
            dwell_q   <= sample ? '0 : dwell_q + DIV_W'(1);
            col_idx_q <= sample ? col_idx_q + 2'd1 : col_idx_q;
            frame_q   <= frame_eval ? '0 : frame_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        if (frame_eval) begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        cand_d  = hit_key;
                        cnt_d   = CNT_ONE;
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!hit) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (hit_key == cand_q) begin
                        cnt_d = cnt_inc;
                    end else begin
                        cand_d = hit_key;
                        cnt_d  = CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!has_cand) begin
                        cnt_d   = CNT_ONE;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (has_cand) state_d = PRESSED;
                    else          cnt_d   = cnt_inc;
                end
                default: state_d = IDLE;
            endcase

            // Acceptance is checked after the update so DEBOUNCE_CNT=1 accepts straight from IDLE.
            if ((state_q == IDLE || state_q == DEBOUNCE) && hit && cnt_d == CNT_MAX) begin
                key_code_d  = cand_d;
                key_valid_d = 1'b1;
                key_held_d  = 1'b1;
                state_d     = PRESSED;
            end
            if ((state_q == PRESSED || state_q == RELEASE) && !has_cand && cnt_d == CNT_MAX) begin
                key_held_d = 1'b0;
                cnt_d      = '0;
                state_d    = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=2, 16-cycle frames).
// A behavioural keypad drives rows from col; expected pulses are queued and matched by a monitor.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] keys;
    int          edge_cnt;
    int          tests;
    int          fails;
    int          fs;

    logic [3:0]  exp_code_q[$];
    int          exp_edge_q[$];

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col[c] && keys[r*4 + c]) row[r] = 1'b0;
            end
        end
    end

    // Rising edges since reset release; a frame starts whenever this is a multiple of 16.
    always @(posedge clk or negedge rst) begin
        if (!rst) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && key_valid === 1'b1) begin
            chk("pulse_was_expected", 32'(exp_code_q.size() > 0), 32'd1);
            if (exp_code_q.size() > 0) begin
                logic [3:0] c;
                int         t;
                c = exp_code_q.pop_front();
                t = exp_edge_q.pop_front();
                chk("pulse_key_code", 32'(key_code), 32'(c));
                chk("pulse_cycle", 32'(edge_cnt), 32'(t));
            end
        end
    end

    task automatic at_edge(input int target);
        int guard;
        guard = 0;
        while (edge_cnt < target && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_cnt != target) chk("reach_edge", 32'(edge_cnt), 32'(target));
    endtask

    task automatic start_keys(input logic [15:0] k);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((edge_cnt % 16) != 0 && guard < 64);
        keys = k;
        fs   = edge_cnt;
    endtask

    task automatic expect_pulse(input logic [3:0] c, input int at);
        exp_code_q.push_back(c);
        exp_edge_q.push_back(at);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        keys  = '0;
        fs    = 0;
        rst   = 1'b0;

        // Reset state and scan start
        repeat (3) @(negedge clk);
        chk("rst_col", 32'(col), 32'h0000000e);
        chk("rst_key_code", 32'(key_code), 32'd0);
        chk("rst_key_valid", 32'(key_valid), 32'd0);
        chk("rst_key_held", 32'(key_held), 32'd0);
        rst = 1'b1;
        at_edge(3);
        chk("col_before_advance", 32'(col), 32'h0000000e);
        at_edge(4);
        chk("col_first_advance", 32'(col), 32'h0000000d);

        // Press key 6 (row 1, col 2) for 5 frames
        start_keys(16'h0040);
        expect_pulse(4'd6, fs + 32);
        at_edge(fs + 31);
        chk("press_held_before", 32'(key_held), 32'd0);
        at_edge(fs + 32);
        chk("press_held_rise", 32'(key_held), 32'd1);
        at_edge(fs + 79);
        chk("press_held_after", 32'(key_held), 32'd1);

        // One-frame release glitch keeps the key held, no new pulse
        start_keys(16'h0000);
        at_edge(fs + 15);
        start_keys(16'h0040);
        at_edge(fs + 31);
        chk("glitch_held", 32'(key_held), 32'd1);

        // Real release: held falls one cycle after the 2nd empty frame
        start_keys(16'h0000);
        at_edge(fs + 31);
        chk("release_held_before", 32'(key_held), 32'd1);
        at_edge(fs + 32);
        chk("release_held_fall", 32'(key_held), 32'd0);
        at_edge(fs + 47);

        // Bounce: alternating present/absent frames never qualify
        for (int i = 0; i < 4; i++) begin
            start_keys(16'h0040);
            at_edge(fs + 15);
            start_keys(16'h0000);
            at_edge(fs + 15);
        end
        chk("bounce_held", 32'(key_held), 32'd0);

        // Keys 1 and 6 together
        start_keys(16'h0042);
`ifndef KEYPAD_MULTI_REJECT_EN
        expect_pulse(4'd1, fs + 32);
`endif
        at_edge(fs + 47);
`ifdef KEYPAD_MULTI_REJECT_EN
        chk("two_keys_held", 32'(key_held), 32'd0);
        chk("two_keys_code", 32'(key_code), 32'd6);
`else
        chk("two_keys_held", 32'(key_held), 32'd1);
        chk("two_keys_code", 32'(key_code), 32'd1);
`endif
        start_keys(16'h0000);
        at_edge(fs + 47);
        chk("two_keys_released", 32'(key_held), 32'd0);

        // Reset while key 6 is held, then full re-debounce
        start_keys(16'h0040);
        expect_pulse(4'd6, fs + 32);
        at_edge(fs + 40);
        chk("mid_held_before_rst", 32'(key_held), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_held", 32'(key_held), 32'd0);
        chk("mid_rst_valid", 32'(key_valid), 32'd0);
        chk("mid_rst_code", 32'(key_code), 32'd0);
        chk("mid_rst_col", 32'(col), 32'h0000000e);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        expect_pulse(4'd6, 32);
        at_edge(31);
        chk("rearm_held_before", 32'(key_held), 32'd0);
        at_edge(32);
        chk("rearm_held_rise", 32'(key_held), 32'd1);
        at_edge(40);

        chk("pulses_outstanding", 32'(exp_code_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
